// File: rtl/led_step_driver.sv
`default_nettype none
// led_step_driver: steps a single lit LED toward a commanded index with fixed pulse spacing.
// Optional LEDR one-hot output is enabled by defining LED_STEP_LEDR_EN.
module led_step_driver #(
  parameter int WIDTH = 10,
  parameter int GAP   = 4,
  parameter int START = 5,
  localparam int IW   = $clog2(WIDTH)
) (
  input  logic          CLOCK_50,
  input  logic          RESET_N,
  input  logic [IW-1:0] target,
  input  logic          start,
  output logic          step_right,
  output logic          step_left,
  output logic [IW-1:0] position,
  output logic          busy,
  output logic          done,
  output logic          err
`ifdef LED_STEP_LEDR_EN
  ,
  output logic [WIDTH-1:0] LEDR
`endif
);

  localparam logic [IW:0]      WIDTH_X  = (IW+1)'(WIDTH);
  localparam logic [IW-1:0]    LAST     = IW'(WIDTH - 1);
  localparam logic [IW-1:0]    START_IX = IW'(START);
  localparam logic [7:0]       GAP_LOAD = 8'(GAP - 1);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  typedef enum logic [1:0] {S_IDLE, S_STEP, S_GAP, S_DONE} state_t;

  state_t        state;
  logic [IW-1:0] tgt_q;
  logic [7:0]    gap_cnt;
  logic [IW-1:0] next_pos;
  logic          target_oor;

  assign target_oor = ({1'b0, target} >= WIDTH_X);

  // Position after the pulse currently on the outputs; ends are clamped.
  always_comb begin
    next_pos = position;
    if (step_right && position != '0)
      next_pos = position - 1'b1;
    else if (step_left && position != LAST)
      next_pos = position + 1'b1;
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state      <= S_IDLE;
      tgt_q      <= '0;
      gap_cnt    <= '0;
      position   <= START_IX;
      step_right <= 1'b0;
      step_left  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
`ifdef LED_STEP_LEDR_EN
      LEDR       <= ONE << START;
`endif
    end else begin
      step_right <= 1'b0;
      step_left  <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            tgt_q <= target;
            busy  <= 1'b1;
            if (target_oor) begin
              state <= S_DONE;
              done  <= 1'b1;
              err   <= 1'b1;
            end else if (target == position) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state      <= S_STEP;
              step_right <= (target < position);
              step_left  <= (target > position);
            end
          end
        end
        S_STEP: begin
          position <= next_pos;
`ifdef LED_STEP_LEDR_EN
          LEDR     <= ONE << next_pos;
`endif
          if (next_pos == tgt_q) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
            gap_cnt <= GAP_LOAD;
            state   <= S_GAP;
          end
        end
        S_GAP: begin
          if (gap_cnt == 8'd0) begin
            state      <= S_STEP;
            step_right <= (tgt_q < position);
            step_left  <= (tgt_q > position);
          end else begin
            gap_cnt <= gap_cnt - 8'd1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_led_step_driver.sv
`default_nettype none
// tb_led_step_driver: scoreboard bench; expected pulse/done events are queued per command.
module tb_led_step_driver;

  localparam int W  = 10;
  localparam int G  = 4;
  localparam int ST = 5;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] target;
  logic       start;
  logic       step_right, step_left, busy, done, err;
  logic [3:0] position;
`ifdef LED_STEP_LEDR_EN
  logic [W-1:0] ledr;
`endif

  led_step_driver #(.WIDTH(W), .GAP(G), .START(ST)) dut (
    .CLOCK_50  (clk),
    .RESET_N   (rst_n),
    .target    (target),
    .start     (start),
    .step_right(step_right),
    .step_left (step_left),
    .position  (position),
    .busy      (busy),
    .done      (done),
    .err       (err)
`ifdef LED_STEP_LEDR_EN
    ,
    .LEDR      (ledr)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [3:0] code;   // {err, done, step_left, step_right}
    logic [3:0] pos;
  } ev_t;

  ev_t q[$];
  int  cyc = 0;
  int  checks = 0;
  int  failures = 0;
  int  bw_lo = 1, bw_hi = 0;
  int  t0;
  int  model_pos;
  bit  mon_en = 1'b0;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      ev_t e;
      check("busy", busy, (cyc >= bw_lo && cyc <= bw_hi));
      check("one_dir", step_right & step_left, 0);
      if (step_right | step_left | done | err) begin
        if (q.size() == 0) begin
          check("spurious", {err, done, step_left, step_right}, 0);
        end else begin
          e = q.pop_front();
          check("ev_cycle", cyc, e.cyc);
          check("ev_code", {err, done, step_left, step_right}, e.code);
          check("ev_pos", position, e.pos);
`ifdef LED_STEP_LEDR_EN
          if (done) check("ledr", ledr, W'(1) << e.pos);
`endif
        end
      end
    end
  end

  // Drive one command; expected events derive from the bench's own position model.
  task automatic issue(input int tgt, input bit dup, input bit wait_done);
    int n, dir, k;
    ev_t e;
    @(negedge clk);
    target = 4'(tgt);
    start  = 1'b1;
    t0     = cyc;
    if (tgt >= W || tgt == model_pos) begin
      e.cyc = t0 + 1; e.code = (tgt >= W) ? 4'b1100 : 4'b0100; e.pos = 4'(model_pos);
      q.push_back(e);
      bw_lo = t0 + 1; bw_hi = t0 + 1;
    end else begin
      dir = (tgt < model_pos) ? -1 : 1;
      n   = (tgt < model_pos) ? model_pos - tgt : tgt - model_pos;
      for (int i = 0; i < n; i++) begin
        e.cyc = t0 + 1 + i * (G + 1);
        e.code = (dir < 0) ? 4'b0001 : 4'b0010;
        e.pos = 4'(model_pos + dir * i);
        q.push_back(e);
      end
      e.cyc = t0 + 2 + (n - 1) * (G + 1); e.code = 4'b0100; e.pos = 4'(tgt);
      q.push_back(e);
      bw_lo = t0 + 1; bw_hi = e.cyc;
      model_pos = tgt;
    end
    @(negedge clk);
    start = 1'b0;
    if (dup) begin
      @(negedge clk);
      @(negedge clk);
      start  = 1'b1;
      target = 4'd0;
      @(negedge clk);
      start  = 1'b0;
    end
    if (wait_done) begin
      k = 0;
      while (q.size() != 0 && k < 300) begin
        @(negedge clk);
        k++;
      end
      check("drain", q.size(), 0);
      repeat (2) @(negedge clk);
      check("final_pos", position, model_pos);
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    target = 4'd0;
    model_pos = ST;
    repeat (3) @(negedge clk);
    check("rst_pos", position, ST);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_pulses", {step_left, step_right}, 0);
`ifdef LED_STEP_LEDR_EN
    check("rst_ledr", ledr, 10'b0000100000);
`endif
    rst_n  = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);

    issue(5, 0, 1);
    issue(12, 0, 1);
    issue(2, 0, 1);
    issue(9, 1, 1);
    issue(5, 0, 1);

    // Reset in cycle 7 of a 5 -> 0 move.
    issue(0, 0, 0);
    while (cyc < t0 + 7) @(negedge clk);
    #2;
    rst_n = 1'b0;
    q.delete();
    bw_lo = 1; bw_hi = 0;
    model_pos = ST;
    #1;
    check("mid_rst_pos", position, ST);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_pulses", {step_left, step_right}, 0);
`ifdef LED_STEP_LEDR_EN
    check("mid_rst_ledr", ledr, 10'b0000100000);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    issue(3, 0, 1);

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
